// File: rtl/dot_tree_feeder.sv
// Sequential front end for DotProductTree: fetches one J column beat-by-beat, drives the tree, returns the dot product.
// Optional: define DOT_TREE_FEEDER_ZERO_DIAG_EN to zero the self-coupling element J_col_o[col].
module dot_tree_feeder #(
  parameter int VECTOR_SIZE      = 256,
  parameter int J_ELEMENT_WIDTH  = 4,
  parameter int BEAT_ELEMS       = 16,
  parameter int ADDR_WIDTH       = 16,
  parameter int INT_RESULT_WIDTH = (J_ELEMENT_WIDTH + 1) + $clog2(VECTOR_SIZE)
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic                                             start_i,
  input  logic [$clog2(VECTOR_SIZE)-1:0]                   col_idx_i,
  input  logic [VECTOR_SIZE-1:0]                           sigma_i,
  output logic                                             busy_o,
  output logic                                             mem_req_o,
  output logic [ADDR_WIDTH-1:0]                            mem_addr_o,
  input  logic                                             mem_gnt_i,
  input  logic                                             mem_rvalid_i,
  input  logic [BEAT_ELEMS*J_ELEMENT_WIDTH-1:0]            mem_rdata_i,
  output logic [VECTOR_SIZE-1:0]                           sigma_o,
  output logic [VECTOR_SIZE-1:0][J_ELEMENT_WIDTH-1:0]      J_col_o,
  input  logic signed [INT_RESULT_WIDTH-1:0]               dot_i,
  output logic                                             result_valid_o,
  input  logic                                             result_ready_i,
  output logic signed [INT_RESULT_WIDTH-1:0]               result_o,
  output logic                                             flip_o
);

  localparam int NBEATS = VECTOR_SIZE / BEAT_ELEMS;
  localparam int CNT_W  = $clog2(NBEATS + 1);
  localparam int COL_W  = $clog2(VECTOR_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SUM,
    DONE
  } state_t;

  state_t                                   r_state;
  logic [COL_W-1:0]                         r_col;
  logic [VECTOR_SIZE-1:0]                   r_sigma;
  logic [VECTOR_SIZE-1:0][J_ELEMENT_WIDTH-1:0] r_jcol;
  logic                                     r_req;
  logic [ADDR_WIDTH-1:0]                    r_addr;
  logic [CNT_W-1:0]                         r_req_cnt;
  logic [CNT_W-1:0]                         r_rsp_cnt;
  logic signed [INT_RESULT_WIDTH-1:0]       r_result;
  logic                                     r_valid;
  logic                                     r_flip;

  logic [ADDR_WIDTH-1:0]                    w_base_addr;
  logic [VECTOR_SIZE-1:0][J_ELEMENT_WIDTH-1:0] w_jcol_next;
  logic                                     w_dot_nonneg;
  logic                                     w_rsp_accept;
  logic                                     w_more_reqs;

  assign w_base_addr  = ADDR_WIDTH'(col_idx_i) * ADDR_WIDTH'(NBEATS);
  assign w_dot_nonneg = ~dot_i[INT_RESULT_WIDTH-1];
  // Responses beyond the outstanding request count are stray and must not advance the column.
  assign w_rsp_accept = mem_rvalid_i && (r_rsp_cnt < r_req_cnt);
  assign w_more_reqs  = (r_req_cnt + CNT_W'(1)) < CNT_W'(NBEATS);

  always_comb begin
    w_jcol_next = r_jcol;
    for (int b = 0; b < NBEATS; b++) begin
      if (CNT_W'(b) == r_rsp_cnt) begin
        for (int e = 0; e < BEAT_ELEMS; e++) begin
          w_jcol_next[b*BEAT_ELEMS + e] = mem_rdata_i[e*J_ELEMENT_WIDTH +: J_ELEMENT_WIDTH];
`ifdef DOT_TREE_FEEDER_ZERO_DIAG_EN
          if ((b*BEAT_ELEMS + e) == int'(r_col)) begin
            w_jcol_next[b*BEAT_ELEMS + e] = '0;
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_col     <= '0;
      r_sigma   <= '0;
      r_jcol    <= '0;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_req_cnt <= '0;
      r_rsp_cnt <= '0;
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_flip    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_col     <= col_idx_i;
            r_sigma   <= sigma_i;
            r_req_cnt <= '0;
            r_rsp_cnt <= '0;
            r_req     <= 1'b1;
            r_addr    <= w_base_addr;
            r_state   <= FETCH;
          end
        end
        FETCH: begin
          if (r_req && mem_gnt_i) begin
            r_req_cnt <= r_req_cnt + CNT_W'(1);
            r_req     <= w_more_reqs;
            if (w_more_reqs) begin
              r_addr <= r_addr + ADDR_WIDTH'(1);
            end
          end
          if (w_rsp_accept) begin
            r_jcol    <= w_jcol_next;
            r_rsp_cnt <= r_rsp_cnt + CNT_W'(1);
            if (r_rsp_cnt == CNT_W'(NBEATS - 1)) begin
              r_state <= SUM;
            end
          end
        end
        // The tree has had a full cycle on the registered J_col/sigma, so dot_i is settled here.
        SUM: begin
          r_result <= dot_i;
          r_flip   <= r_sigma[r_col] != w_dot_nonneg;
          r_valid  <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          if (result_ready_i) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i)
    (r_state == FETCH && mem_rvalid_i) |-> (r_rsp_cnt < r_req_cnt));

  assign busy_o         = (r_state != IDLE);
  assign mem_req_o      = r_req;
  assign mem_addr_o     = r_addr;
  assign sigma_o        = r_sigma;
  assign J_col_o        = r_jcol;
  assign result_valid_o = r_valid;
  assign result_o       = r_result;
  assign flip_o         = r_flip;

endmodule

// File: tb/tb_dot_tree_feeder.sv
// Bench for dot_tree_feeder: memory responder, behavioural dot tree, vector table and scoreboard.
// Honours DOT_TREE_FEEDER_ZERO_DIAG_EN in its expected-value model.
module tb_dot_tree_feeder;

  localparam int VS     = 8;
  localparam int JW     = 4;
  localparam int BEAT   = 4;
  localparam int AW     = 16;
  localparam int NB     = VS / BEAT;
  localparam int RW     = (JW + 1) + $clog2(VS);
  localparam int NWORDS = VS * NB;
`ifdef DOT_TREE_FEEDER_ZERO_DIAG_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    start_i;
  logic [$clog2(VS)-1:0]   col_idx_i;
  logic [VS-1:0]           sigma_i;
  logic                    busy_o;
  logic                    mem_req_o;
  logic [AW-1:0]           mem_addr_o;
  logic                    mem_gnt_i = 1'b0;
  logic                    mem_rvalid_i = 1'b0;
  logic [BEAT*JW-1:0]      mem_rdata_i = '0;
  logic [VS-1:0]           sigma_o;
  logic [VS-1:0][JW-1:0]   J_col_o;
  logic signed [RW-1:0]    dot_i;
  logic                    result_valid_o;
  logic                    result_ready_i;
  logic signed [RW-1:0]    result_o;
  logic                    flip_o;

  typedef struct {
    int            col;
    logic [VS-1:0] sigma;
    int            jFill;
    int            stallBeat;
    int            stallLen;
    int            readyDelay;
    bit            checkConst;
    int            expRes;
    logic          expFlip;
    int            expLat;
  } vec_t;

  typedef struct {
    int   res;
    logic flip;
  } exp_t;

  logic [BEAT*JW-1:0] memWords [NWORDS];
  exp_t               expQ [$];
  vec_t               vecs [9];
  int                 testsRun = 0;
  int                 testsFailed = 0;
  int                 stallBeat = 0;
  int                 stallLen = 0;
  int                 stallCnt = 0;
  int                 expStallAddr = 0;
  logic               pendValid = 1'b0;
  int                 pendAddr = 0;
  int                 dotAcc;

  dot_tree_feeder #(
    .VECTOR_SIZE(VS), .J_ELEMENT_WIDTH(JW), .BEAT_ELEMS(BEAT), .ADDR_WIDTH(AW), .INT_RESULT_WIDTH(RW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .col_idx_i(col_idx_i), .sigma_i(sigma_i),
    .busy_o(busy_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .sigma_o(sigma_o), .J_col_o(J_col_o),
    .dot_i(dot_i), .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_o(result_o), .flip_o(flip_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural stand-in for the combinational DotProductTree.
  always_comb begin
    dotAcc = 0;
    for (int i = 0; i < VS; i++) begin
      dotAcc += sigma_o[i] ? int'(J_col_o[i]) : -int'(J_col_o[i]);
    end
    dot_i = RW'(dotAcc);
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Memory: grants unless a stall is programmed on the current beat; data returns one cycle after grant.
  always @(negedge clk_i) begin
    mem_rvalid_i = pendValid;
    mem_rdata_i  = memWords[pendAddr];
    mem_gnt_i    = 1'b1;
    if (mem_req_o && stallCnt < stallLen && (int'(mem_addr_o) % NB) == stallBeat) begin
      mem_gnt_i = 1'b0;
      stallCnt++;
      checkOutput("stall_addr_held", longint'(mem_addr_o), longint'(expStallAddr));
    end
    pendValid = mem_req_o && mem_gnt_i;
    pendAddr  = int'(mem_addr_o) % NWORDS;
  end

  task automatic fillMem(input int jFill);
    for (int w = 0; w < NWORDS; w++) begin
      for (int k = 0; k < BEAT; k++) begin
        memWords[w][k*JW +: JW] = (jFill < 0) ? JW'($urandom_range(0, 15)) : JW'(jFill);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int                    cyc;
    int                    jv;
    int                    modelRes;
    logic                  modelFlip;
    logic [VS-1:0][JW-1:0] expCol;
    exp_t                  e;
    fillMem(v.jFill);
    modelRes = 0;
    for (int i = 0; i < VS; i++) begin
      jv = int'(memWords[v.col*NB + i/BEAT][(i%BEAT)*JW +: JW]);
      if (ZD && i == v.col) jv = 0;
      expCol[i] = JW'(jv);
      modelRes += v.sigma[i] ? jv : -jv;
    end
    modelFlip    = v.sigma[v.col] != (modelRes >= 0);
    stallBeat    = v.stallBeat;
    stallLen     = v.stallLen;
    stallCnt     = 0;
    expStallAddr = v.col*NB + v.stallBeat;
    start_i   = 1'b1;
    col_idx_i = ($clog2(VS))'(v.col);
    sigma_i   = v.sigma;
    expQ.push_back('{modelRes, modelFlip});
    @(negedge clk_i);
    start_i   = 1'b0;
    col_idx_i = ($clog2(VS))'($urandom);
    sigma_i   = VS'($urandom);
    cyc = 1;
    checkOutput("busy_cycle1", longint'(busy_o), 1);
    checkOutput("req_cycle1", longint'(mem_req_o), 1);
    checkOutput("addr_cycle1", longint'(mem_addr_o), longint'(v.col*NB));
    while (!result_valid_o && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
    end
    checkOutput("valid_timeout", longint'(result_valid_o), 1);
    if (!result_valid_o) return;
    checkOutput("latency", longint'(cyc), longint'(v.expLat));
    checkOutput("j_col", longint'(J_col_o), longint'(expCol));
    checkOutput("sigma_out", longint'(sigma_o), longint'(v.sigma));
    for (int d = 0; d < v.readyDelay; d++) begin
      if (d == 1) start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      checkOutput("hold_valid", longint'(result_valid_o), 1);
      checkOutput("hold_busy", longint'(busy_o), 1);
      checkOutput("hold_result", longint'(result_o), longint'(expQ[0].res));
    end
    e = expQ.pop_front();
    checkOutput("result", longint'(result_o), longint'(e.res));
    checkOutput("flip", longint'(flip_o), longint'(e.flip));
    if (v.checkConst) begin
      checkOutput("result_const", longint'(result_o), longint'(v.expRes));
      checkOutput("flip_const", longint'(flip_o), longint'(v.expFlip));
    end
    result_ready_i = 1'b1;
    if (v.readyDelay > 0) start_i = 1'b1;
    @(negedge clk_i);
    result_ready_i = 1'b0;
    start_i = 1'b0;
    checkOutput("valid_after_hs", longint'(result_valid_o), 0);
    checkOutput("busy_after_hs", longint'(busy_o), 0);
  endtask

  initial begin
    vec_t rv;
    // Field order: col, sigma, jFill, stallBeat, stallLen, readyDelay, checkConst, expRes, expFlip, expLat
    vecs[0] = '{0, 8'hFF, 1,  0, 0, 0, !ZD, 8,    1'b0, 5};
    vecs[1] = '{0, 8'h00, 1,  0, 0, 0, !ZD, -8,   1'b0, 5};
    vecs[2] = '{0, 8'h0F, 15, 0, 0, 0, !ZD, 0,    1'b0, 5};
    vecs[3] = '{0, 8'h01, 2,  0, 0, 0, !ZD, -12,  1'b1, 5};
    vecs[4] = '{6, 8'hFF, 1,  1, 3, 0, !ZD, 8,    1'b0, 8};
    vecs[5] = '{7, 8'h3C, 1,  0, 0, 5, !ZD, 0,    1'b1, 5};
    vecs[6] = '{4, 8'hFF, 15, 0, 2, 0, !ZD, 120,  1'b0, 7};
    vecs[7] = '{4, 8'h00, 15, 0, 0, 1, !ZD, -120, 1'b0, 5};
    vecs[8] = '{3, 8'hFF, 1,  0, 0, 0, 1'b1, ZD ? 7 : 8, 1'b0, 5};

    rst_i = 1'b1;
    start_i = 1'b0;
    col_idx_i = '0;
    sigma_i = '0;
    result_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checkOutput("rst_busy", longint'(busy_o), 0);
    checkOutput("rst_req", longint'(mem_req_o), 0);
    checkOutput("rst_addr", longint'(mem_addr_o), 0);
    checkOutput("rst_valid", longint'(result_valid_o), 0);
    checkOutput("rst_flip", longint'(flip_o), 0);
    checkOutput("rst_result", longint'(result_o), 0);
    checkOutput("rst_sigma", longint'(sigma_o), 0);
    checkOutput("rst_jcol", longint'(J_col_o), 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int t = 0; t < 8; t++) begin
      applyStimulus(vecs[t]);
    end

    for (int r = 0; r < 4; r++) begin
      rv = '{$urandom_range(0, VS-1), VS'($urandom), -1, $urandom_range(0, NB-1),
             $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, 0, 1'b0, 0};
      rv.expLat = 5 + rv.stallLen;
      applyStimulus(rv);
    end

    // Abort a job with reset right after the first grant; its trailing beat must be dropped.
    fillMem(9);
    stallLen = 0;
    start_i = 1'b1;
    col_idx_i = 3'd5;
    sigma_i = 8'hFF;
    @(negedge clk_i);
    start_i = 1'b0;
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("abort_busy", longint'(busy_o), 0);
    checkOutput("abort_req", longint'(mem_req_o), 0);
    checkOutput("abort_addr", longint'(mem_addr_o), 0);
    checkOutput("abort_sigma", longint'(sigma_o), 0);
    checkOutput("abort_jcol", longint'(J_col_o), 0);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("trailing_rvalid_dropped", longint'(J_col_o), 0);
    checkOutput("idle_after_abort", longint'(busy_o), 0);

    applyStimulus(vecs[8]);

    checkOutput("scoreboard_empty", longint'(expQ.size()), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
